// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: per-stage valid bits, halt-drain FSM,
// latch enables and bubbles. Define FORWARD_EN to enable EX operand forwarding (load-use stall only).
module pipeline_hazard_ctrl #(
   parameter int REG_W     = 5,
   parameter int BR_STAGE  = 2,
   parameter int DRAIN_CNT = 3
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit_i,
   input  logic             dhit_i,
   input  logic             mem_access_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic [REG_W-1:0] ex_rs_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic [REG_W-1:0] ex_wsel_i,
   input  logic [REG_W-1:0] mem_wsel_i,
   input  logic [REG_W-1:0] wb_wsel_i,
   input  logic             ex_wen_i,
   input  logic             mem_wen_i,
   input  logic             wb_wen_i,
   input  logic             ex_memread_i,
   input  logic             br_taken_i,
   input  logic             jump_id_i,
   input  logic             halt_id_i,
   output logic             pc_en_o,
   output logic             imemREN_o,
   output logic             en_ifid_o,
   output logic             en_idex_o,
   output logic             en_exmem_o,
   output logic             en_memwb_o,
   output logic             bub_ifid_o,
   output logic             bub_idex_o,
   output logic             bub_exmem_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic [3:0]       valid_o,
   output logic             halt_o
);

   localparam int ID  = 0;
   localparam int EX  = 1;
   localparam int MEM = 2;
   localparam int WB  = 3;
   localparam int CNT_W = $clog2(DRAIN_CNT + 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CNT - 1);
   localparam logic BR_MEM = (BR_STAGE == 3) ? 1'b1 : 1'b0;

   generate
      if (BR_STAGE != 2 && BR_STAGE != 3) begin : g_bad_br_stage
         $error("pipeline_hazard_ctrl: BR_STAGE must be 2 (EX) or 3 (MEM)");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       valid_q, valid_d;

   logic ex_wen_s, mem_wen_s, mem_wait_s, rs_used_s, rt_used_s, stall_s;

   // Destination hit on a used, non-zero ID source.
   function automatic logic src_hit(input logic wen, input logic [REG_W-1:0] wsel,
                                    input logic rs_used, input logic [REG_W-1:0] rs,
                                    input logic rt_used, input logic [REG_W-1:0] rt);
      src_hit = wen & (wsel != {REG_W{1'b0}}) &
                ((rs_used & (rs == wsel)) | (rt_used & (rt == wsel)));
   endfunction

   assign ex_wen_s   = ex_wen_i & valid_q[EX];
   assign mem_wen_s  = mem_wen_i & valid_q[MEM];
   assign mem_wait_s = valid_q[MEM] & mem_access_i & ~dhit_i;
   assign rs_used_s  = valid_q[ID] & id_use_rs_i;
   assign rt_used_s  = valid_q[ID] & id_use_rt_i;

`ifdef FORWARD_EN
   logic wb_wen_s;

   // EX/MEM result beats MEM/WB; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                          input logic m_wen, input logic [REG_W-1:0] m_wsel,
                                          input logic w_wen, input logic [REG_W-1:0] w_wsel);
      if (m_wen && (m_wsel != {REG_W{1'b0}}) && (m_wsel == src)) begin
         fwd_sel = 2'b10;
      end else if (w_wen && (w_wsel != {REG_W{1'b0}}) && (w_wsel == src)) begin
         fwd_sel = 2'b01;
      end else begin
         fwd_sel = 2'b00;
      end
   endfunction

   assign wb_wen_s = wb_wen_i & valid_q[WB];
   assign stall_s  = src_hit(ex_memread_i & valid_q[EX] & ex_wen_s, ex_wsel_i,
                             rs_used_s, id_rs_i, rt_used_s, id_rt_i);
   assign fwd_a_o  = fwd_sel(ex_rs_i, mem_wen_s, mem_wsel_i, wb_wen_s, wb_wsel_i);
   assign fwd_b_o  = fwd_sel(ex_rt_i, mem_wen_s, mem_wsel_i, wb_wen_s, wb_wsel_i);
`else
   logic unused_fwd_s;

   // Without forwarding every in-flight producer ahead of WB stalls ID.
   assign stall_s = src_hit(ex_wen_s, ex_wsel_i, rs_used_s, id_rs_i, rt_used_s, id_rt_i) |
                    src_hit(mem_wen_s, mem_wsel_i, rs_used_s, id_rs_i, rt_used_s, id_rt_i);
   assign fwd_a_o = 2'b00;
   assign fwd_b_o = 2'b00;
   assign unused_fwd_s = ^{ex_rs_i, ex_rt_i, wb_wsel_i, wb_wen_i, ex_memread_i};
`endif

   // State, drain counter and stage valid bits.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_RUN;
         cnt_q   <= {CNT_W{1'b0}};
         valid_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Prioritised control: halted, memory wait, redirect, drain, halt entry, stall, jump, fetch wait.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en_o     = 1'b1;
      imemREN_o   = 1'b1;
      en_ifid_o   = 1'b1;
      en_idex_o   = 1'b1;
      en_exmem_o  = 1'b1;
      en_memwb_o  = 1'b1;
      bub_ifid_o  = 1'b0;
      bub_idex_o  = 1'b0;
      bub_exmem_o = 1'b0;
      if (state_q == ST_HALTED) begin
         pc_en_o    = 1'b0;
         imemREN_o  = 1'b0;
         en_ifid_o  = 1'b0;
         en_idex_o  = 1'b0;
         en_exmem_o = 1'b0;
         en_memwb_o = 1'b0;
      end else if (mem_wait_s) begin
         pc_en_o    = 1'b0;
         en_ifid_o  = 1'b0;
         en_idex_o  = 1'b0;
         en_exmem_o = 1'b0;
         en_memwb_o = 1'b0;
      end else if (br_taken_i) begin
         // An older branch squashes a halt that is in ID or still draining.
         bub_ifid_o  = 1'b1;
         bub_idex_o  = 1'b1;
         bub_exmem_o = BR_MEM;
         state_d     = ST_RUN;
         cnt_d       = {CNT_W{1'b0}};
      end else if (state_q == ST_DRAIN) begin
         pc_en_o    = 1'b0;
         imemREN_o  = 1'b0;
         en_ifid_o  = 1'b0;
         bub_idex_o = 1'b1;
         cnt_d      = cnt_q + CNT_W'(1);
         if (cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
         end else begin
            state_d = ST_DRAIN;
         end
      end else if (valid_q[ID] && halt_id_i) begin
         pc_en_o    = 1'b0;
         bub_ifid_o = 1'b1;
         state_d    = ST_DRAIN;
         cnt_d      = {CNT_W{1'b0}};
      end else if (stall_s) begin
         pc_en_o    = 1'b0;
         en_ifid_o  = 1'b0;
         bub_idex_o = 1'b1;
      end else if (valid_q[ID] && jump_id_i) begin
         bub_ifid_o = 1'b1;
      end else if (!ihit_i) begin
         pc_en_o    = 1'b0;
         bub_ifid_o = 1'b1;
      end else begin
         pc_en_o = 1'b1;
      end
   end

   // Enabled latches copy valid from the previous stage; bubbles clear it.
   always_comb begin
      valid_d = valid_q;
      if (en_ifid_o) begin
         valid_d[ID] = ~bub_ifid_o;
      end else begin
         valid_d[ID] = valid_q[ID];
      end
      if (en_idex_o) begin
         valid_d[EX] = valid_q[ID] & ~bub_idex_o;
      end else begin
         valid_d[EX] = valid_q[EX];
      end
      if (en_exmem_o) begin
         valid_d[MEM] = valid_q[EX] & ~bub_exmem_o;
      end else begin
         valid_d[MEM] = valid_q[MEM];
      end
      if (en_memwb_o) begin
         valid_d[WB] = valid_q[MEM];
      end else begin
         valid_d[WB] = valid_q[WB];
      end
   end

   assign valid_o = valid_q;
   assign halt_o  = (state_q == ST_HALTED);

endmodule
